// File: rtl/mdiv_pkg.sv
// Shared constants for the multiply/divide issue controller: FSM state
// encoding, writeback exception codes and the exception-code helper.
package mdiv_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ABORT  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_MULT    = 2'b01;
  localparam logic [1:0] EXC_DIV     = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  // A unit-raised exception is reported according to the kind of op in flight.
  function automatic logic [1:0] exc_for_op(input logic is_div);
    return is_div ? EXC_DIV : EXC_MULT;
  endfunction

endpackage

// File: rtl/mdiv_timeout_counter.sv
// Watchdog counter: synchronous clear, count enable, and a terminal flag
// raised when the count reaches TIMEOUT_CYCLES-1 (the count then holds).
module mdiv_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic terminal_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign terminal_o = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !terminal_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mdiv_issue_ctrl.sv
// Pipeline-side issue controller for the iterative multiply/divide unit.
// Optional feature: define MDIV_DIVZERO_SHORTCUT_EN to complete div-by-zero locally.
module mdiv_issue_ctrl
  import mdiv_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              op_is_div,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [REG_W-1:0]  dest_reg,
  input  logic              flush,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_operand_a,
  output logic [DATA_W-1:0] md_operand_b,
  input  logic              md_result_rdy,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  output logic              stall,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_result,
  output logic [REG_W-1:0]  wb_dest,
  output logic [1:0]        wb_exc_code,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and payload holds while valid && !ready.

  logic [2:0]        state_q, state_d;
  logic              is_div_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [REG_W-1:0]  dest_q;
  logic [DATA_W-1:0] result_q, result_d;
  logic [1:0]        exc_q, exc_d;
  logic              accept;
  logic              divzero_hit;
  logic              wb_load;
  logic              cnt_clr;
  logic              cnt_en;
  logic              timeout;

`ifdef MDIV_DIVZERO_SHORTCUT_EN
  assign divzero_hit = op_is_div && (operand_b == '0);
`else
  assign divzero_hit = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && start_valid && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = divzero_hit ? ST_DONE : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_d = flush ? ST_ABORT : ST_WAIT;
      end
      ST_WAIT: begin
        // A flush that coincides with the unit finishing has nothing left to drain.
        if (flush) begin
          state_d = (md_result_rdy || timeout) ? ST_IDLE : ST_ABORT;
        end else if (md_result_rdy || timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_ABORT: begin
        if (md_result_rdy || timeout) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (flush || wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wb_load = (accept && divzero_hit) ||
                   ((state_q == ST_WAIT) && !flush && (md_result_rdy || timeout));

  // Ready beats timeout in the same cycle; any exception forces a zero result.
  always_comb begin
    result_d = '0;
    exc_d    = EXC_NONE;
    if (state_q == ST_WAIT) begin
      if (md_result_rdy) begin
        if (md_exception) exc_d = exc_for_op(is_div_q);
        else              result_d = md_result;
      end else begin
        exc_d = EXC_TIMEOUT;
      end
    end else begin
      exc_d = EXC_DIV;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      dest_q   <= '0;
      result_q <= '0;
      exc_q    <= EXC_NONE;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_div_q <= op_is_div;
        opa_q    <= operand_a;
        opb_q    <= operand_b;
        dest_q   <= dest_reg;
      end
      if (wb_load) begin
        result_q <= result_d;
        exc_q    <= exc_d;
      end
    end
  end

  assign cnt_clr = (state_q == ST_IDLE) || (state_q == ST_LAUNCH);
  assign cnt_en  = (state_q == ST_WAIT) || (state_q == ST_ABORT);

  mdiv_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .terminal_o(timeout)
  );

  assign start_ready  = (state_q == ST_IDLE);
  assign stall        = (state_q != ST_IDLE);
  assign md_ctrl_mult = (state_q == ST_LAUNCH) && !is_div_q;
  assign md_ctrl_div  = (state_q == ST_LAUNCH) &&  is_div_q;
  assign md_operand_a = opa_q;
  assign md_operand_b = opb_q;
  assign wb_valid     = (state_q == ST_DONE);
  assign wb_result    = result_q;
  assign wb_dest      = dest_q;
  assign wb_exc_code  = exc_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mdiv_issue_ctrl.sv
// Self-checking bench for mdiv_issue_ctrl: directed vector table, corner
// sequences and randomized ops checked against a behavioural model.
`timescale 1ns/1ps
module tb_mdiv_issue_ctrl;
  import mdiv_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int TO     = 40;
  localparam int CNT_W  = 6;
  localparam int W      = DATA_W + REG_W + 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic              start_valid, start_ready, op_is_div, flush;
  logic [DATA_W-1:0] operand_a, operand_b;
  logic [REG_W-1:0]  dest_reg;
  logic              md_ctrl_mult, md_ctrl_div;
  logic [DATA_W-1:0] md_operand_a, md_operand_b;
  logic              md_result_rdy, md_exception;
  logic [DATA_W-1:0] md_result;
  logic              stall, wb_valid, wb_ready;
  logic [DATA_W-1:0] wb_result;
  logic [REG_W-1:0]  wb_dest;
  logic [1:0]        wb_exc_code;
  logic [2:0]        dbg_state;

  mdiv_issue_ctrl #(
    .DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_is_div(op_is_div), .operand_a(operand_a), .operand_b(operand_b),
    .dest_reg(dest_reg), .flush(flush),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
    .md_result_rdy(md_result_rdy), .md_result(md_result), .md_exception(md_exception),
    .stall(stall), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_result(wb_result), .wb_dest(wb_dest), .wb_exc_code(wb_exc_code),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- unit responder ----------------
  int                rsp_cnt = 0;
  int                rsp_lat = 0;
  bit                rsp_force = 0;
  logic [DATA_W-1:0] rsp_val;
  logic              rsp_exc;
  int                mult_pulses = 0;
  int                div_pulses  = 0;

  task automatic unit_compute(input logic is_div, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    if (is_div) begin
      if (b == '0) begin rsp_val = $urandom; rsp_exc = 1'b1; end
      else begin rsp_val = a / b; rsp_exc = rsp_force; end
    end else begin
      rsp_val = prod[31:0];
      rsp_exc = rsp_force || (prod[63:32] != 32'd0);
    end
  endtask

  // One clock: sample/drive 1ns after the rising edge; the unit answers rsp_lat cycles after its pulse.
  task automatic tick();
    @(posedge clock);
    #1;
    md_result_rdy = 1'b0;
    md_exception  = 1'($urandom_range(0, 1));
    md_result     = $urandom;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        md_result_rdy = 1'b1;
        md_result     = rsp_val;
        md_exception  = rsp_exc;
      end
    end
    if (md_ctrl_mult) mult_pulses++;
    if (md_ctrl_div)  div_pulses++;
    if (md_ctrl_mult || md_ctrl_div) begin
      unit_compute(md_ctrl_div, md_operand_a, md_operand_b);
      rsp_cnt = rsp_lat;
    end
  endtask

  // ---------------- vectors and model ----------------
  typedef struct {
    bit                is_div;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_W-1:0]  dest;
    int                lat;        // cycles from start pulse to rdy; 0 = never
    bit                force_exc;
    int                hold;       // cycles wb_ready stays low in DONE
    logic [DATA_W-1:0] exp_res;
    logic [1:0]        exp_code;
    int                exp_lat;    // cycles from accept edge to wb_valid visible
    int                exp_mp;
    int                exp_dp;
  } vec_t;

  function automatic void model(inout vec_t v);
    logic [63:0] prod;
    bit          unit_exc;
    bit          shortcut;
    prod     = 64'(v.a) * 64'(v.b);
    shortcut = 1'b0;
`ifdef MDIV_DIVZERO_SHORTCUT_EN
    shortcut = v.is_div && (v.b == '0);
`endif
    if (shortcut) begin
      v.exp_res = '0; v.exp_code = 2'b10; v.exp_lat = 0; v.exp_mp = 0; v.exp_dp = 0;
      return;
    end
    v.exp_mp = v.is_div ? 0 : 1;
    v.exp_dp = v.is_div ? 1 : 0;
    if (v.lat == 0 || v.lat > TO) begin
      v.exp_res = '0; v.exp_code = 2'b11; v.exp_lat = TO + 1;
    end else begin
      unit_exc  = v.force_exc || (v.is_div ? (v.b == '0) : (prod[63:32] != 32'd0));
      v.exp_lat = v.lat + 1;
      if (unit_exc) begin
        v.exp_res  = '0;
        v.exp_code = v.is_div ? 2'b10 : 2'b01;
      end else begin
        v.exp_res  = v.is_div ? (v.a / v.b) : prod[31:0];
        v.exp_code = 2'b00;
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!start_ready && n < 100) begin tick(); n++; end
    chk("wait_ready", 64'(start_ready), 64'd1);
  endtask

  task automatic accept_op(input vec_t v);
    wait_ready();
    start_valid = 1'b1; op_is_div = v.is_div; operand_a = v.a; operand_b = v.b; dest_reg = v.dest;
    rsp_lat = v.lat; rsp_force = v.force_exc; mult_pulses = 0; div_pulses = 0;
    tick();
    start_valid = 1'b0;
    op_is_div = 1'($urandom); operand_a = $urandom; operand_b = $urandom; dest_reg = REG_W'($urandom);
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int n;
    int stall_low;
    logic [W-1:0] exp;
    logic [W-1:0] got;
    exp_q.push_back({v.exp_res, v.dest, v.exp_code});
    accept_op(v);
    n = 0; stall_low = 0;
    while (!wb_valid && n < 100) begin
      if (!stall || start_ready) stall_low++;
      tick(); n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(v.exp_lat));
    chk({tag, "_stall"}, 64'(stall_low), 64'd0);
    exp = exp_q.pop_front();
    for (int h = 0; h < v.hold; h++) begin
      got = {wb_result, wb_dest, wb_exc_code};
      chk({tag, "_hold_wb"}, 64'(got), 64'(exp));
      chk({tag, "_hold_valid"}, 64'({wb_valid, stall}), 64'(2'b11));
      tick();
    end
    got = {wb_result, wb_dest, wb_exc_code};
    chk({tag, "_wb"}, 64'(got), 64'(exp));
    chk({tag, "_valid"}, 64'({wb_valid, stall, start_ready}), 64'(3'b110));
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk({tag, "_release"}, 64'({wb_valid, stall, start_ready}), 64'(3'b001));
    chk({tag, "_pulses"}, 64'({8'(mult_pulses), 8'(div_pulses)}), 64'({8'(v.exp_mp), 8'(v.exp_dp)}));
  endtask

  // ---------------- test ----------------
  vec_t vecs[9];
  vec_t v;
  int   n;
  int   seen;

  initial begin
    reset_n = 1'b0; start_valid = 1'b0; op_is_div = 1'b0; operand_a = '0; operand_b = '0;
    dest_reg = '0; flush = 1'b0; md_result_rdy = 1'b0; md_result = '0; md_exception = 1'b0;
    wb_ready = 1'b0;

    //                  div  a             b         dest   lat exc hold res           code   lat mp dp
    vecs[0] = '{1'b0, 32'd7,        32'd6,    5'd3,  16, 0, 5, 32'd42,        2'b00, 17, 1, 0};
    vecs[1] = '{1'b1, 32'd100,      32'd7,    5'd9,  32, 0, 1, 32'd14,        2'b00, 33, 0, 1};
`ifdef MDIV_DIVZERO_SHORTCUT_EN
    vecs[2] = '{1'b1, 32'd5,        32'd0,    5'd4,   8, 0, 0, 32'd0,         2'b10,  0, 0, 0};
`else
    vecs[2] = '{1'b1, 32'd5,        32'd0,    5'd4,   8, 0, 0, 32'd0,         2'b10,  9, 0, 1};
`endif
    vecs[3] = '{1'b0, 32'd3,        32'd5,    5'd1,   0, 0, 0, 32'd0,         2'b11, 41, 1, 0};
    vecs[4] = '{1'b0, 32'd3,        32'd5,    5'd2,  40, 0, 0, 32'd15,        2'b00, 41, 1, 0};
    vecs[5] = '{1'b0, 32'd3,        32'd5,    5'd5,  41, 0, 2, 32'd0,         2'b11, 41, 1, 0};
    vecs[6] = '{1'b0, 32'h10000,    32'h10000, 5'd6,  5, 0, 0, 32'd0,         2'b01,  6, 1, 0};
    vecs[7] = '{1'b1, 32'd9,        32'd3,    5'd7,   1, 1, 0, 32'd0,         2'b10,  2, 0, 1};
    vecs[8] = '{1'b1, 32'hFFFFFFFF, 32'h10,   5'd31,  2, 0, 3, 32'h0FFFFFFF,  2'b00,  3, 0, 1};

    // Reset state
    #1;
    chk("reset_outputs", 64'({start_ready, stall, wb_valid, md_ctrl_mult, md_ctrl_div, dbg_state}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE}));
    chk("reset_data", 64'({md_operand_a, wb_result}), 64'd0);
    chk("reset_wb", 64'({wb_dest, wb_exc_code}), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // start_valid with flush in IDLE: no accept
    mult_pulses = 0; div_pulses = 0; rsp_lat = 0;
    start_valid = 1'b1; flush = 1'b1; op_is_div = 1'b0; operand_a = 32'd2; operand_b = 32'd2;
    tick();
    start_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_ready", 64'({start_ready, stall}), 64'(2'b10));
    tick();
    chk("idle_flush_pulses", 64'(mult_pulses + div_pulses), 64'd0);

    // Flush in WAIT, late rdy at cycle 20: no writeback, back to IDLE after rdy
    v = '{1'b1, 32'd50, 32'd5, 5'd12, 20, 0, 0, 32'd0, 2'b00, 0, 0, 0};
    accept_op(v);
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 6; seen = 0;
    while (!start_ready && n < 100) begin
      if (wb_valid) seen++;
      tick(); n++;
    end
    chk("abort_release_cycle", 64'(n), 64'd21);
    chk("abort_no_wb", 64'(seen + int'(wb_valid)), 64'd0);
    chk("abort_pulse", 64'(div_pulses), 64'd1);
    run_op("after_abort", vecs[0]);

    // Flush in DONE: wb_valid drops next cycle
    v = '{1'b0, 32'd2, 32'd3, 5'd8, 3, 0, 0, 32'd6, 2'b00, 4, 1, 0};
    accept_op(v);
    n = 0;
    while (!wb_valid && n < 100) begin tick(); n++; end
    chk("done_flush_latency", 64'(n), 64'd4);
    chk("done_flush_result", 64'(wb_result), 64'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("done_flush_drop", 64'({wb_valid, start_ready}), 64'(2'b01));

    // Reset mid-WAIT; the unit's late rdy afterwards is ignored
    v = '{1'b0, 32'd9, 32'd9, 5'd10, 30, 0, 0, 32'd0, 2'b00, 0, 0, 0};
    accept_op(v);
    for (int i = 0; i < 10; i++) tick();
    chk("mid_wait_stall", 64'(stall), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset_ctrl", 64'({start_ready, stall, wb_valid, md_ctrl_mult, md_ctrl_div, dbg_state}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE}));
    chk("midreset_data", 64'({md_operand_a, wb_result}), 64'd0);
    chk("midreset_wb", 64'({md_operand_b[7:0], wb_dest, wb_exc_code}), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (wb_valid || !start_ready) seen++;
      tick();
    end
    chk("late_rdy_ignored", 64'(seen), 64'd0);

    // Randomized ops against the model
    for (int i = 0; i < 24; i++) begin
      v.is_div    = 1'($urandom_range(0, 1));
      v.a         = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5000)) : $urandom;
      v.b         = ($urandom_range(0, 7) == 0) ? 32'd0 :
                    (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      v.dest      = REG_W'($urandom);
      v.lat       = $urandom_range(0, 45);
      v.force_exc = ($urandom_range(0, 7) == 0);
      v.hold      = $urandom_range(0, 3);
      model(v);
      run_op($sformatf("rnd%0d", i), v);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
